cp0_debug_unit: RTL and testbench
=================================

CP0_DEBUG_UNIT -- requirements
Module: cp0_debug_unit

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of breakpoint channels, legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 16, width of each per-channel hit counter.
REQ-003 SHALL define IDX_W as max(1, clog2(NUM_CH)).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 wr_en  in  1  CP0 register write strobe (MTC0).
REQ-007 wr_sel  in  5  register select for writes.
REQ-008 wr_idx  in  IDX_W  channel index for writes.
REQ-009 wr_data  in  32  write data.
REQ-010 rd_sel  in  5  register select for reads.
REQ-011 rd_idx  in  IDX_W  channel index for reads.
REQ-012 rd_data  out  32  registered read data.
REQ-013 mem_valid  in  1  memory-stage instruction valid.
REQ-014 mem_stall  in  1  memory stage stalled.
REQ-015 mem_pc  in  32  memory-stage PC.
REQ-016 mem_addr  in  32  memory-stage data address.
REQ-017 mem_load, mem_store  in  1 each  access type.
REQ-018 kernel_mode  in  1  1 = kernel, 0 = user.
REQ-019 trap_req  out  1  debug trap request, level.
REQ-020 trap_ack  in  1  trap accepted by exception logic.
REQ-021 trap_ch  out  IDX_W  channel that raised the pending trap.

Function
REQ-022 Register map (sel): 3 BPC[idx], 11 BPCM[idx], 5 BDA[idx], 9 BDAM[idx], 7 DCIC (global, idx ignored), 16 HITCNT[idx]; other sel values SHALL read 0 and ignore writes.
REQ-023 DCIC bits: [7:0] sticky per-channel hit status, write-1-to-clear; [23] master enable; [24] PC enable; [25] data enable; [26] load enable; [27] store enable; [29] user enable; [30] kernel enable; [31] trap enable; all other bits SHALL read 0.
REQ-024 Status bits at or above NUM_CH SHALL read 0 and SHALL never set.
REQ-025 Qualifier q = mem_valid & ~mem_stall & DCIC[23] & (kernel_mode ? DCIC[30] : DCIC[29]).
REQ-026 PC hit ch i = q & DCIC[24] & (((mem_pc ^ BPC[i]) & BPCM[i]) == 0).
REQ-027 Data hit ch i = q & DCIC[25] & ((mem_load & DCIC[26]) | (mem_store & DCIC[27])) & (((mem_addr ^ BDA[i]) & BDAM[i]) == 0).
REQ-028 hit[i] = PC hit | data hit; status[i] SHALL set on the same edge.
REQ-029 Comparison in the cycle of a write SHALL use the pre-write register values.
REQ-030 When a status bit is set by a hit and W1C-cleared in the same cycle, the set SHALL win.
REQ-031 rd_data SHALL equal the selected register one cycle after rd_sel/rd_idx are presented, reflecting state as of that edge.
REQ-032 Trap FSM states IDLE and PEND; IDLE->PEND when any hit[i] and DCIC[31]; PEND->IDLE on trap_ack.
REQ-033 trap_req SHALL be 1 exactly in PEND.
REQ-034 trap_ch SHALL latch the lowest-index hitting channel on IDLE->PEND and hold while in PEND.
REQ-035 Hits during PEND SHALL update status only; they SHALL NOT re-arm the FSM or change trap_ch.
REQ-036 trap_ack in IDLE SHALL be ignored.
REQ-037 Clearing DCIC[31] while in PEND SHALL NOT drop trap_req.

Reset
REQ-038 On rst_n low: all BPC/BPCM/BDA/BDAM/DCIC/HITCNT = 0, FSM = IDLE, trap_req = 0, trap_ch = 0, rd_data = 0.
REQ-039 Reset mid-PEND SHALL drop trap_req immediately (asynchronous).

Configuration
REQ-040 Macro CP0_DEBUG_HITCNT_EN: defined -> HITCNT[i] increments on each hit[i], saturates at all-ones, and any write to sel 16 clears HITCNT[idx]; undefined -> no counters synthesised, sel 16 reads 0 and ignores writes.

Verification
REQ-041 BPC[0]=0x80001000, BPCM[0]=0xFFFFFFF0, DCIC=0xC1800000, mem_pc=0x8000100C valid -> status[0]=1 next edge, trap_req=1, trap_ch=0.
REQ-042 Both channels match the same data address on a store with DCIC[27]=1 -> status=0x03, trap_ch=0; trap_ack -> trap_req=0 next edge.
REQ-043 A match with mem_stall=1, or in user mode with DCIC[29]=0 -> no status change, trap_req stays 0.
REQ-044 W1C of 0x01 to DCIC coinciding with a new ch0 hit -> status[0] stays 1.
REQ-045 With CP0_DEBUG_HITCNT_EN and CNT_W=4: 17 hits on ch1 -> HITCNT[1] reads 0xF; write to sel 16, idx 1 -> reads 0.
REQ-046 Assert rst_n low while trap_req=1 -> trap_req=0 and DCIC reads 0 after release.

Source files
------------

// File: rtl/cp0_debug_if.sv
// CP0 debug unit bus: register access port, memory-stage snoop and trap handshake.
// master = pipeline/CP0 side driving the unit, slave = the debug unit itself.
interface cp0_debug_if #(
    parameter int unsigned IDX_W = 1
);
    logic             wr_en;
    logic [4:0]       wr_sel;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic [4:0]       rd_sel;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_data;
    logic             mem_valid;
    logic             mem_stall;
    logic [31:0]      mem_pc;
    logic [31:0]      mem_addr;
    logic             mem_load;
    logic             mem_store;
    logic             kernel_mode;
    logic             trap_req;
    logic             trap_ack;
    logic [IDX_W-1:0] trap_ch;

    modport master (
        output wr_en, wr_sel, wr_idx, wr_data, rd_sel, rd_idx,
        output mem_valid, mem_stall, mem_pc, mem_addr, mem_load, mem_store, kernel_mode,
        output trap_ack,
        input  rd_data, trap_req, trap_ch
    );

    modport slave (
        input  wr_en, wr_sel, wr_idx, wr_data, rd_sel, rd_idx,
        input  mem_valid, mem_stall, mem_pc, mem_addr, mem_load, mem_store, kernel_mode,
        input  trap_ack,
        output rd_data, trap_req, trap_ch
    );
endinterface

// File: rtl/cp0_debug_unit.sv
// CP0 hardware breakpoint unit: per-channel PC/data-address comparators, sticky hit
// status in DCIC, a two-state trap request FSM and a registered read port.
// Optional per-channel saturating hit counters at sel 16 when CP0_DEBUG_HITCNT_EN is defined.
module cp0_debug_unit #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 16
) (
    input logic        clk,
    input logic        rst_n,
    cp0_debug_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [4:0] SelBpc    = 5'd3;
    localparam logic [4:0] SelBda    = 5'd5;
    localparam logic [4:0] SelDcic   = 5'd7;
    localparam logic [4:0] SelBdam   = 5'd9;
    localparam logic [4:0] SelBpcm   = 5'd11;
    localparam logic [4:0] SelHitcnt = 5'd16;

    // Implemented DCIC control bits; bit 28 and [22:8] are reserved.
    localparam logic [31:0] CtrlMask   = 32'hEF80_0000;
    localparam logic [7:0]  StatusMask = 8'((1 << NUM_CH) - 1);

    typedef enum logic [0:0] {StIdle, StPend} state_e;

    logic [31:0]      bpc_q  [NUM_CH];
    logic [31:0]      bpcm_q [NUM_CH];
    logic [31:0]      bda_q  [NUM_CH];
    logic [31:0]      bdam_q [NUM_CH];
    logic [31:0]      ctrl_q, ctrl_d;
    logic [7:0]       status_q, status_d;
    logic [31:0]      rd_data_q, rd_data_d;
    state_e           state_q, state_d;
    logic [IDX_W-1:0] trap_ch_q, trap_ch_d;
    logic [NUM_CH-1:0] hit;
    logic [IDX_W-1:0] first_ch;
    logic             qual;
    logic             wr_idx_ok;
    logic             rd_idx_ok;
    logic             dcic_wr;

    assign wr_idx_ok = 32'(bus.wr_idx) < NUM_CH;
    assign rd_idx_ok = 32'(bus.rd_idx) < NUM_CH;
    assign dcic_wr   = bus.wr_en && (bus.wr_sel == SelDcic);

    // Breakpoint match against pre-write register values; also find lowest hitting channel.
    always_comb begin
        hit      = '0;
        first_ch = '0;
        qual = bus.mem_valid && !bus.mem_stall && ctrl_q[23] &&
               (bus.kernel_mode ? ctrl_q[30] : ctrl_q[29]);
        for (int i = 0; i < int'(NUM_CH); i++) begin
            hit[i] = (qual && ctrl_q[24] &&
                      (((bus.mem_pc ^ bpc_q[i]) & bpcm_q[i]) == 32'd0)) ||
                     (qual && ctrl_q[25] &&
                      ((bus.mem_load && ctrl_q[26]) || (bus.mem_store && ctrl_q[27])) &&
                      (((bus.mem_addr ^ bda_q[i]) & bdam_q[i]) == 32'd0));
        end
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (hit[i]) first_ch = IDX_W'(i);
        end
    end

    // Per-channel breakpoint registers written by MTC0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                bpc_q[i]  <= '0;
                bpcm_q[i] <= '0;
                bda_q[i]  <= '0;
                bdam_q[i] <= '0;
            end
        end else if (bus.wr_en && wr_idx_ok) begin
            case (bus.wr_sel)
                SelBpc:  bpc_q[bus.wr_idx]  <= bus.wr_data;
                SelBpcm: bpcm_q[bus.wr_idx] <= bus.wr_data;
                SelBda:  bda_q[bus.wr_idx]  <= bus.wr_data;
                SelBdam: bdam_q[bus.wr_idx] <= bus.wr_data;
                default: ;
            endcase
        end
    end

    // DCIC next state: a hit setting a status bit overrides a same-cycle W1C.
    always_comb begin
        ctrl_d   = ctrl_q;
        status_d = status_q;
        if (dcic_wr) begin
            ctrl_d   = bus.wr_data & CtrlMask;
            status_d = status_q & ~bus.wr_data[7:0];
        end
        status_d = (status_d | 8'(hit)) & StatusMask;
    end

    // DCIC state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            status_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
        end
    end

`ifdef CP0_DEBUG_HITCNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    // Saturating hit counters; a write to sel 16 clears the addressed counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (bus.wr_en && (bus.wr_sel == SelHitcnt) && wr_idx_ok &&
                    (bus.wr_idx == IDX_W'(i))) begin
                    cnt_q[i] <= '0;
                end else if (hit[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end
`endif

    // Read mux over current state; captured into rd_data on the next edge.
    always_comb begin
        rd_data_d = '0;
        case (bus.rd_sel)
            SelBpc:    if (rd_idx_ok) rd_data_d = bpc_q[bus.rd_idx];
            SelBpcm:   if (rd_idx_ok) rd_data_d = bpcm_q[bus.rd_idx];
            SelBda:    if (rd_idx_ok) rd_data_d = bda_q[bus.rd_idx];
            SelBdam:   if (rd_idx_ok) rd_data_d = bdam_q[bus.rd_idx];
            SelDcic:   rd_data_d = ctrl_q | {24'd0, status_q};
`ifdef CP0_DEBUG_HITCNT_EN
            SelHitcnt: if (rd_idx_ok) rd_data_d = 32'(cnt_q[bus.rd_idx]);
`endif
            default:   rd_data_d = '0;
        endcase
    end

    // Registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    // Trap FSM next state: arm on a hit with trap enable, channel frozen while pending.
    always_comb begin
        state_d   = state_q;
        trap_ch_d = trap_ch_q;
        unique case (state_q)
            StIdle: begin
                if ((|hit) && ctrl_q[31]) begin
                    state_d   = StPend;
                    trap_ch_d = first_ch;
                end
            end
            StPend: begin
                if (bus.trap_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Trap FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            trap_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            trap_ch_q <= trap_ch_d;
        end
    end

    assign bus.trap_req = (state_q == StPend);
    assign bus.trap_ch  = trap_ch_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_cp0_debug_unit.sv
// Self-checking bench for cp0_debug_unit: directed scenarios then randomized traffic,
// all compared against a register-level behavioural model of the debug unit.
module tb_cp0_debug_unit;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 1;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cp0_debug_if #(.IDX_W(IDX_W)) bus ();

    cp0_debug_unit #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural model state.
    logic [31:0]       m_bpc  [NUM_CH];
    logic [31:0]       m_bpcm [NUM_CH];
    logic [31:0]       m_bda  [NUM_CH];
    logic [31:0]       m_bdam [NUM_CH];
    logic [31:0]       m_ctrl;
    logic [NUM_CH-1:0] m_stat;
    int                m_cnt  [NUM_CH];
    bit                m_pend;
    int                m_ch;
    logic [31:0]       m_rd;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] addr_pool [4] = '{32'h0000_1000, 32'h0000_1004, 32'h0000_2000, 32'h0000_2010};
    logic [31:0] mask_pool [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_0000, 32'h0000_0000};
    logic [4:0]  sel_pool  [8] = '{5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd16, 5'd0, 5'd31};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int sel, input int idx);
        case (sel)
            3:  return m_bpc[idx];
            11: return m_bpcm[idx];
            5:  return m_bda[idx];
            9:  return m_bdam[idx];
            7:  return m_ctrl | 32'(m_stat);
`ifdef CP0_DEBUG_HITCNT_EN
            16: return 32'(m_cnt[idx]);
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NUM_CH); i++) begin
            m_bpc[i] = '0; m_bpcm[i] = '0; m_bda[i] = '0; m_bdam[i] = '0; m_cnt[i] = 0;
        end
        m_ctrl = '0; m_stat = '0; m_pend = 0; m_ch = 0; m_rd = '0;
    endtask

    // One clock of the model, driven by whatever is currently on the bus.
    task automatic model_clock();
        bit qual, pc_hit, da_hit;
        bit [NUM_CH-1:0] hit;
        int sel, idx;
        sel  = int'(bus.wr_sel);
        idx  = int'(bus.wr_idx);
        m_rd = model_read(int'(bus.rd_sel), int'(bus.rd_idx));
        qual = bus.mem_valid && !bus.mem_stall && m_ctrl[23] &&
               (bus.kernel_mode ? m_ctrl[30] : m_ctrl[29]);
        for (int i = 0; i < int'(NUM_CH); i++) begin
            pc_hit = qual && m_ctrl[24] && ((bus.mem_pc & m_bpcm[i]) == (m_bpc[i] & m_bpcm[i]));
            da_hit = qual && m_ctrl[25] &&
                     ((bus.mem_load && m_ctrl[26]) || (bus.mem_store && m_ctrl[27])) &&
                     ((bus.mem_addr & m_bdam[i]) == (m_bda[i] & m_bdam[i]));
            hit[i] = pc_hit || da_hit;
        end
        if (m_pend) begin
            if (bus.trap_ack) m_pend = 0;
        end else if (hit != 0 && m_ctrl[31]) begin
            m_pend = 1;
            for (int i = int'(NUM_CH) - 1; i >= 0; i--) if (hit[i]) m_ch = i;
        end
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (bus.wr_en && sel == 16 && idx == i) m_cnt[i] = 0;
            else if (hit[i] && m_cnt[i] < CNT_MAX) m_cnt[i] = m_cnt[i] + 1;
        end
        if (bus.wr_en) begin
            case (sel)
                3:  m_bpc[idx]  = bus.wr_data;
                11: m_bpcm[idx] = bus.wr_data;
                5:  m_bda[idx]  = bus.wr_data;
                9:  m_bdam[idx] = bus.wr_data;
                7: begin
                    m_ctrl = bus.wr_data & 32'hEF80_0000;
                    m_stat = m_stat & ~bus.wr_data[NUM_CH-1:0];
                end
                default: ;
            endcase
        end
        m_stat = m_stat | hit;
    endtask

    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
        check("trap_req", 32'(bus.trap_req), 32'(m_pend));
        check("trap_ch", 32'(bus.trap_ch), 32'(m_ch));
        check("rd_data", bus.rd_data, m_rd);
    endtask

    task automatic idle();
        bus.wr_en = 0; bus.wr_sel = '0; bus.wr_idx = '0; bus.wr_data = '0;
        bus.mem_valid = 0; bus.mem_stall = 0; bus.mem_pc = '0; bus.mem_addr = '0;
        bus.mem_load = 0; bus.mem_store = 0; bus.kernel_mode = 1; bus.trap_ack = 0;
    endtask

    task automatic wr(input int sel, input int idx, input logic [31:0] data);
        bus.wr_en = 1; bus.wr_sel = 5'(sel); bus.wr_idx = IDX_W'(idx); bus.wr_data = data;
        cycle();
        bus.wr_en = 0;
    endtask

    task automatic rd(input int sel, input int idx);
        bus.rd_sel = 5'(sel); bus.rd_idx = IDX_W'(idx);
        cycle();
    endtask

    task automatic access(input logic [31:0] pc, input logic [31:0] addr, input bit ld,
                          input bit st, input bit kern, input bit stall);
        bus.mem_valid = 1; bus.mem_pc = pc; bus.mem_addr = addr; bus.mem_load = ld;
        bus.mem_store = st; bus.kernel_mode = kern; bus.mem_stall = stall;
        cycle();
        idle();
    endtask

    task automatic ack();
        bus.trap_ack = 1;
        cycle();
        bus.trap_ack = 0;
    endtask

    initial begin
        idle();
        bus.rd_sel = '0; bus.rd_idx = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset trap_req", 32'(bus.trap_req), 32'd0);
        check("reset trap_ch", 32'(bus.trap_ch), 32'd0);
        check("reset rd_data", bus.rd_data, 32'd0);
        rst_n = 1;
        rd(7, 0);
        check("reset dcic", bus.rd_data, 32'd0);

        // PC breakpoint on channel 0; channel 1 set to a non-matching PC.
        wr(3, 0, 32'h8000_1000);
        wr(11, 0, 32'hFFFF_FFF0);
        wr(11, 1, 32'hFFFF_FFFF);
        wr(7, 0, 32'hC180_0000);
        access(32'h8000_100C, 32'h0, 0, 0, 1, 0);
        check("pc hit trap_req", 32'(bus.trap_req), 32'd1);
        check("pc hit trap_ch", 32'(bus.trap_ch), 32'd0);
        rd(7, 0);
        check("pc hit dcic", bus.rd_data, 32'hC180_0001);
        ack();
        check("ack drops trap", 32'(bus.trap_req), 32'd0);

        // Both channels match the same store address.
        wr(5, 0, 32'h1234_5678);
        wr(5, 1, 32'h1234_5678);
        wr(9, 0, 32'hFFFF_FFFF);
        wr(9, 1, 32'hFFFF_FFFF);
        wr(7, 0, 32'hCA80_0003);
        access(32'h8000_100C, 32'h1234_5678, 0, 1, 1, 0);
        check("dual hit trap_ch", 32'(bus.trap_ch), 32'd0);
        rd(7, 0);
        check("dual hit dcic", bus.rd_data, 32'hCA80_0003);
        ack();
        check("dual ack", 32'(bus.trap_req), 32'd0);

        // Stalled access and user-mode access with user enable off do nothing.
        wr(7, 0, 32'hCA80_0003);
        access(32'h0, 32'h1234_5678, 0, 1, 1, 1);
        access(32'h0, 32'h1234_5678, 0, 1, 0, 0);
        check("qualified off trap_req", 32'(bus.trap_req), 32'd0);
        rd(7, 0);
        check("qualified off dcic", bus.rd_data, 32'hCA80_0000);

        // W1C colliding with a fresh hit: the hit wins.
        wr(7, 0, 32'h4A80_0000);
        bus.wr_en = 1; bus.wr_sel = 5'd7; bus.wr_idx = '0; bus.wr_data = 32'h4A80_0001;
        access(32'h0, 32'h1234_5678, 0, 1, 1, 0);
        rd(7, 0);
        check("w1c vs hit dcic", bus.rd_data, 32'h4A80_0003);

        // 17 hits on channel 1 only; counter saturates then clears on write.
        wr(5, 0, 32'h0);
        wr(16, 1, 32'h0);
        repeat (17) access(32'h0, 32'h1234_5678, 0, 1, 1, 0);
        rd(16, 1);
`ifdef CP0_DEBUG_HITCNT_EN
        check("hitcnt saturate", bus.rd_data, 32'h0000_000F);
`else
        check("hitcnt absent", bus.rd_data, 32'h0);
`endif
        wr(16, 1, 32'h1234);
        rd(16, 1);
        check("hitcnt clear", bus.rd_data, 32'h0);

        // Trap from channel 1; clearing trap enable keeps the request up.
        wr(7, 0, 32'hCA80_0003);
        access(32'h0, 32'h1234_5678, 0, 1, 1, 0);
        check("ch1 trap_ch", 32'(bus.trap_ch), 32'd1);
        wr(7, 0, 32'h4A80_0000);
        check("trap enable cleared", 32'(bus.trap_req), 32'd1);

        // Asynchronous reset while pending.
        wr(7, 0, 32'hCA80_0003);
        #2;
        rst_n = 0;
        #1;
        check("async reset trap_req", 32'(bus.trap_req), 32'd0);
        model_reset();
        idle();
        bus.rd_sel = 5'd7; bus.rd_idx = '0;
        @(posedge clk);
        #1;
        rst_n = 1;
        rd(7, 0);
        check("post reset dcic", bus.rd_data, 32'd0);

        // Randomized traffic against the model.
        wr(7, 0, 32'hEF80_0000);
        for (int n = 0; n < 400; n++) begin
            bus.wr_en  = ($urandom_range(0, 4) == 0);
            bus.wr_sel = sel_pool[$urandom_range(0, 7)];
            bus.wr_idx = IDX_W'($urandom_range(0, 1));
            case (bus.wr_sel)
                5'd3, 5'd5: bus.wr_data = addr_pool[$urandom_range(0, 3)];
                5'd9, 5'd11: bus.wr_data = mask_pool[$urandom_range(0, 3)];
                5'd7: bus.wr_data = $urandom | 32'h0080_0000;
                default: bus.wr_data = $urandom;
            endcase
            bus.mem_valid   = ($urandom_range(0, 3) != 0);
            bus.mem_stall   = ($urandom_range(0, 4) == 0);
            bus.mem_pc      = addr_pool[$urandom_range(0, 3)];
            bus.mem_addr    = addr_pool[$urandom_range(0, 3)];
            bus.mem_load    = 1'($urandom);
            bus.mem_store   = 1'($urandom);
            bus.kernel_mode = 1'($urandom);
            bus.trap_ack    = ($urandom_range(0, 2) == 0);
            bus.rd_sel      = sel_pool[$urandom_range(0, 7)];
            bus.rd_idx      = IDX_W'($urandom_range(0, 1));
            cycle();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
